// File: rtl/frame_packer.sv
// -----------------------------------------------------------------------------
// frame_packer
//
// Takes the synchronization stage's burst stream and repackages it as
// AXI-Stream packets of at most MAX_LEN words. A DEPTH-word FIFO absorbs DMA
// stalls. The source runs at ADC rate and is never back-pressured. If the FIFO
// runs out of room, the current burst is cut short: its last stored word is
// marked end-of-packet and end-of-burst, and the rest of the burst is dropped.
//
// Parameters
//   DEPTH    FIFO depth in words (power of 2, >= 4)
//   MAX_LEN  maximum words per output packet (2..65535)
//
// Ports
//   aclk           clock for all logic
//   aresetn        asynchronous active-low reset
//   enable         1 = accept new bursts (sampled only between bursts)
//   s_valid        input sample valid
//   s_ready        1 once out of reset; the source is never stalled
//   s_data         input sample {Q[15:0], I[15:0]}
//   s_user         beat is the first of a burst
//   s_last         beat is the last of a burst
//   m_axis_tvalid  output word valid
//   m_axis_tready  downstream ready
//   m_axis_tdata   output word
//   m_axis_tlast   last word of the packet
//   drop_count     number of truncated bursts, saturating at 16'hFFFF
//   irq            one-cycle pulse after the final word of a burst is taken
// -----------------------------------------------------------------------------
module frame_packer #(
    parameter int DEPTH   = 256,
    parameter int MAX_LEN = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_user,
    input  logic        s_last,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [15:0] drop_count,
    output logic        irq
);

    localparam int AW = $clog2(DEPTH);

    // Occupancy thresholds. A burst is truncated by the word that would fill
    // the second-to-last slot. The final slot stays spare, so a packet split
    // or a burst end that lands on that same edge still has somewhere to go.
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] NEAR_LVL = (AW + 1)'(DEPTH - 2);
    localparam logic [15:0] SPLIT_AT = 16'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    typedef struct packed {
        logic        eof;   // final word of the whole burst (drives irq)
        logic        last;  // final word of the output packet (drives tlast)
        logic [31:0] data;
    } entry_t;

    // ------------------------------------------------------------------ FIFO
    entry_t      mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        full;
    logic        near_full;

    // Pointers carry one extra wrap bit, so the difference gives 0..DEPTH.
    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == FULL_LVL);
    assign near_full = (count >= NEAR_LVL);

    // -------------------------------------------------------- write decoding
    state_t      state;
    state_t      state_n;
    logic [15:0] wcnt;
    logic [15:0] wcnt_n;
    logic        wr_en;
    entry_t      wr_entry;
    logic        drop_inc;

    always_comb begin
        // NOTE: every signal driven here gets a default first. Without the
        // defaults, a branch that skips an assignment would infer a latch.
        wr_en    = 1'b0;
        wr_entry = '{eof: 1'b0, last: 1'b0, data: s_data};
        state_n  = state;
        wcnt_n   = wcnt;
        drop_inc = 1'b0;

        case (state)
            IDLE: begin
                // A new burst is opened only here, so enable has no effect
                // on a burst that is already in progress.
                if (s_valid && s_user && enable) begin
                    if (full) begin
                        // No room even for one word: the whole burst is lost.
                        drop_inc = 1'b1;
                        state_n  = s_last ? IDLE : DROP;
                    end else if (s_last) begin
                        // Single-word burst.
                        wr_en         = 1'b1;
                        wr_entry.eof  = 1'b1;
                        wr_entry.last = 1'b1;
                    end else if (near_full) begin
                        wr_en         = 1'b1;
                        wr_entry.eof  = 1'b1;
                        wr_entry.last = 1'b1;
                        drop_inc      = 1'b1;
                        state_n       = DROP;
                    end else begin
                        wr_en   = 1'b1;
                        wcnt_n  = 16'd1;
                        state_n = PASS;
                    end
                end
            end

            PASS: begin
                // Inside a burst s_user is plain data and does not restart it.
                if (s_valid) begin
                    if (full) begin
                        // Reached only when a split or burst end consumed the
                        // spare slot. Nothing can be stored, so drop the rest.
                        drop_inc = 1'b1;
                        wcnt_n   = '0;
                        state_n  = s_last ? IDLE : DROP;
                    end else if (s_last) begin
                        wr_en         = 1'b1;
                        wr_entry.eof  = 1'b1;
                        wr_entry.last = 1'b1;
                        wcnt_n        = '0;
                        state_n       = IDLE;
                    end else if (wcnt == SPLIT_AT) begin
                        // Packet reached MAX_LEN: close it, burst continues.
                        wr_en         = 1'b1;
                        wr_entry.last = 1'b1;
                        wcnt_n        = '0;
                    end else if (near_full) begin
                        wr_en         = 1'b1;
                        wr_entry.eof  = 1'b1;
                        wr_entry.last = 1'b1;
                        wcnt_n        = '0;
                        drop_inc      = 1'b1;
                        state_n       = DROP;
                    end else begin
                        wr_en  = 1'b1;
                        wcnt_n = wcnt + 16'd1;
                    end
                end
            end

            DROP: begin
                if (s_valid && s_last) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------ FSM and counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= IDLE;
            wcnt       <= '0;
            wr_ptr     <= '0;
            drop_count <= '0;
            s_ready    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every
            // block reads the pre-edge value and the simulation has no race.
            state   <= state_n;
            wcnt    <= wcnt_n;
            s_ready <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (drop_inc && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 16'd1;
            end
        end
    end

    // NOTE: the storage array has no reset. Only slots between the pointers
    // are ever read, and the pointers themselves are reset.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_entry;
        end
    end

    // ---------------------------------------------------------- output stage
    // The head entry stays in the FIFO until it is handed over, so the output
    // register always shows the oldest unconsumed word. While stalled, it
    // reloads the same slot, which keeps tdata/tlast stable.
    logic        pop;
    logic [AW:0] rd_ptr_n;
    logic [AW:0] avail;
    logic        out_eof;

    assign pop      = m_axis_tvalid & m_axis_tready;
    assign rd_ptr_n = rd_ptr + {{AW{1'b0}}, pop};
    // Words written on this same edge are not counted yet. They appear one
    // cycle later, which gives the one-cycle write-to-valid latency.
    assign avail    = wr_ptr - rd_ptr_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_ptr        <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            out_eof       <= 1'b0;
            irq           <= 1'b0;
        end else begin
            rd_ptr        <= rd_ptr_n;
            m_axis_tvalid <= (avail != '0);
            if (avail != '0) begin
                m_axis_tdata <= mem[rd_ptr_n[AW-1:0]].data;
                m_axis_tlast <= mem[rd_ptr_n[AW-1:0]].last;
                out_eof      <= mem[rd_ptr_n[AW-1:0]].eof;
            end
            irq <= pop & out_eof;
        end
    end

endmodule

// File: tb/tb_frame_packer.sv
// -----------------------------------------------------------------------------
// tb_frame_packer
//
// Self-checking bench for frame_packer (DEPTH=16, MAX_LEN=64). Each beat
// driven into the DUT passes through a small behavioural model. The model
// pushes the expected {eof, last, data} entry onto a scoreboard queue. A
// monitor on the falling edge compares every presented word against the
// queue head and pops it on handshake. irq is checked every cycle against
// the eof flag of the word handed over on the previous edge.
// -----------------------------------------------------------------------------
module tb_frame_packer;

    localparam int DEPTH   = 16;
    localparam int MAX_LEN = 64;

    logic        aclk          = 1'b0;
    logic        aresetn       = 1'b0;
    logic        enable        = 1'b0;
    logic        s_valid       = 1'b0;
    logic [31:0] s_data        = '0;
    logic        s_user        = 1'b0;
    logic        s_last        = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic        s_ready;
    logic        m_axis_tvalid;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] drop_count;
    logic        irq;

    frame_packer #(
        .DEPTH  (DEPTH),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_user       (s_user),
        .s_last       (s_last),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tlast (m_axis_tlast),
        .drop_count   (drop_count),
        .irq          (irq)
    );

    always #5 aclk = ~aclk;

    // ------------------------------------------------------------- checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------ model/scoreboard
    typedef struct packed {
        logic        eof;
        logic        last;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   m_state = 0;   // 0 idle, 1 in burst, 2 dropping
    int   m_wcnt  = 0;
    int   m_drops = 0;

    task automatic push(input logic eof, input logic last, input logic [31:0] d);
        sb.push_back('{eof: eof, last: last, data: d});
    endtask

    // Expected FIFO writes for one beat, following the specified rules.
    task automatic model_beat(input logic [31:0] d, input logic u, input logic l);
        case (m_state)
            0: if (u && enable) begin
                if (l) push(1'b1, 1'b1, d);
                else if (sb.size() >= DEPTH - 2) begin
                    push(1'b1, 1'b1, d); m_drops++; m_state = 2;
                end else begin
                    push(1'b0, 1'b0, d); m_wcnt = 1; m_state = 1;
                end
            end
            1: begin
                if (l) begin
                    push(1'b1, 1'b1, d); m_wcnt = 0; m_state = 0;
                end else if (m_wcnt == MAX_LEN - 1) begin
                    push(1'b0, 1'b1, d); m_wcnt = 0;
                end else if (sb.size() >= DEPTH - 2) begin
                    push(1'b1, 1'b1, d); m_wcnt = 0; m_drops++; m_state = 2;
                end else begin
                    push(1'b0, 1'b0, d); m_wcnt++;
                end
            end
            default: if (l) m_state = 0;
        endcase
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_beat(input logic [31:0] d, input logic u, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_user  = u;
        s_last  = l;
        model_beat(d, u, l);
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0;
        s_user  = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic burst(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            drive_beat(base + 32'(i), i == 0, i == n - 1);
        end
        idle_inputs();
    endtask

    task automatic drain(input string tag);
        int waited = 0;
        while (sb.size() != 0 && waited < 2000) begin
            @(negedge aclk);
            waited++;
        end
        if (sb.size() != 0) check({tag, "_drain_timeout"}, 64'(sb.size()), 64'd0);
        repeat (4) @(negedge aclk);
    endtask

    // -------------------------------------------------------------- monitor
    int n_words = 0;
    int n_irq   = 0;
    bit irq_exp = 1'b0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            irq_exp = 1'b0;
        end else begin
            check("irq", irq, irq_exp);
            if (irq) n_irq++;
            irq_exp = 1'b0;
            if (m_axis_tvalid) begin
                if (sb.size() == 0) begin
                    check("spurious_word", m_axis_tdata, 64'hDEAD_0000_0000_0000);
                end else begin
                    check("tdata", m_axis_tdata, sb[0].data);
                    check("tlast", m_axis_tlast, sb[0].last);
                    if (m_axis_tready) begin
                        irq_exp = sb[0].eof;
                        void'(sb.pop_front());
                        n_words++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- stimulus
    initial begin
        repeat (3) @(negedge aclk);
        check("rst_s_ready", s_ready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_irq", irq, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("s_ready_after_rst", s_ready, 1);
        enable        = 1'b1;
        m_axis_tready = 1'b1;

        // 1) five-beat burst and first-word latency
        n_words = 0; n_irq = 0;
        drive_beat(32'h1000_0000, 1'b1, 1'b0);
        check("t1_tvalid_after_1_edge", m_axis_tvalid, 0);
        drive_beat(32'h1000_0001, 1'b0, 1'b0);
        check("t1_tvalid_after_2_edges", m_axis_tvalid, 1);
        check("t1_first_word", m_axis_tdata, 32'h1000_0000);
        drive_beat(32'h1000_0002, 1'b0, 1'b0);
        drive_beat(32'h1000_0003, 1'b0, 1'b0);
        drive_beat(32'h1000_0004, 1'b0, 1'b1);
        idle_inputs();
        drain("t1");
        check("t1_words", n_words, 5);
        check("t1_irq_count", n_irq, 1);

        // 2) long burst split into 64/64/22
        n_words = 0; n_irq = 0;
        burst(150, 32'h2000_0000);
        drain("t2");
        check("t2_words", n_words, 150);
        check("t2_irq_count", n_irq, 1);

        // 3) overflow while downstream is stalled
        n_words = 0; n_irq = 0;
        m_axis_tready = 1'b0;
        burst(40, 32'h3000_0000);
        repeat (5) @(negedge aclk);
        check("t3_drop_count", drop_count, 1);
        check("t3_stalled_valid", m_axis_tvalid, 1);
        check("t3_stalled_head", m_axis_tdata, 32'h3000_0000);
        m_axis_tready = 1'b1;
        drain("t3");
        check("t3_words", n_words, 15);
        check("t3_irq_count", n_irq, 1);

        // 4) enable handling
        n_words = 0; n_irq = 0;
        enable = 1'b0;
        burst(3, 32'h4000_0000);
        repeat (10) @(negedge aclk);
        check("t4_disabled_words", n_words, 0);
        enable = 1'b1;
        drive_beat(32'h4100_0000, 1'b1, 1'b0);
        enable = 1'b0;
        for (int i = 1; i < 10; i++) drive_beat(32'h4100_0000 + 32'(i), 1'b0, i == 9);
        idle_inputs();
        drain("t4");
        check("t4_midburst_words", n_words, 10);
        check("t4_irq_count", n_irq, 1);
        n_words = 0;
        burst(5, 32'h4200_0000);
        repeat (10) @(negedge aclk);
        check("t4_next_burst_ignored", n_words, 0);

        // 5) single-beat burst
        n_words = 0; n_irq = 0;
        enable = 1'b1;
        drive_beat(32'h0001_FFFF, 1'b1, 1'b1);
        idle_inputs();
        drain("t5");
        check("t5_words", n_words, 1);
        check("t5_irq_count", n_irq, 1);

        // 6) reset mid-burst with seven words held
        n_words = 0; n_irq = 0;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 7; i++) drive_beat(32'h6000_0000 + 32'(i), i == 0, 1'b0);
        repeat (2) @(negedge aclk);
        check("t6_valid_before_rst", m_axis_tvalid, 1);
        #2;
        aresetn = 1'b0;
        sb.delete();
        m_state = 0; m_wcnt = 0; m_drops = 0;
        #1;
        check("t6_tvalid_in_rst", m_axis_tvalid, 0);
        @(negedge aclk);
        @(negedge aclk);
        aresetn       = 1'b1;
        m_axis_tready = 1'b1;
        for (int i = 7; i < 10; i++) drive_beat(32'h6000_0000 + 32'(i), 1'b0, i == 9);
        idle_inputs();
        repeat (10) @(negedge aclk);
        check("t6_no_output_after_rst", n_words, 0);
        check("t6_drop_count_cleared", drop_count, 0);
        burst(3, 32'h6100_0000);
        drain("t6");
        check("t6_recovered_words", n_words, 3);
        check("t6_irq_count", n_irq, 1);

        check("final_drop_count", drop_count, 16'(m_drops));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
